// File: rtl/spart_driver_buf_pkg.sv
// Shared definitions for the SPART processor-side driver: bus addresses,
// baud table, divisor helper and driver state type.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Indexed by br_cfg.
  localparam int unsigned BAUD_TABLE [4] = '{4800, 9600, 19200, 38400};

  function automatic logic [15:0] calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned q;
    q = clk_freq / (16 * baud);
    return 16'(q - 1);
  endfunction

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    WR,
    GAP
  } drv_state_t;

endpackage

// File: rtl/spart_driver_buf_sync_fifo.sv
// Synchronous FIFO with count-based full/empty and a combinational head output.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/spart_driver_buf.sv
// SPART driver: programs the baud divisor from br_cfg, then echoes received
// bytes through a FIFO. Define SPART_DRIVER_CRLF_EN to expand CR into CR LF.
module spart_driver_buf
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 br_cfg,
  output logic                       iocs,
  output logic                       iorw,
  input  logic                       rda,
  input  logic                       tbr,
  output logic [1:0]                 ioaddr,
  inout  wire  [7:0]                 databus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       cfg_done
);

  localparam logic [15:0] DIV [4] = '{
    calc_div(CLK_FREQ, BAUD_TABLE[0]), calc_div(CLK_FREQ, BAUD_TABLE[1]),
    calc_div(CLK_FREQ, BAUD_TABLE[2]), calc_div(CLK_FREQ, BAUD_TABLE[3])
  };

`ifdef SPART_DRIVER_CRLF_EN
  localparam int unsigned RD_SLOTS = 2;
  logic r_crlf;
`else
  localparam int unsigned RD_SLOTS = 1;
`endif

  drv_state_t r_state;
  logic       r_iocs;
  logic       r_iorw;
  logic [1:0] r_ioaddr;
  logic       r_drive;
  logic [7:0] r_dout;
  logic [1:0] r_br;
  logic       r_cfg_done;

  logic                       w_push;
  logic                       w_pop;
  logic [7:0]                 w_push_data;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(DEPTH+1)-1:0] w_count;
  logic [7:0]                 w_head;
  logic                       w_room;

`ifdef SPART_DRIVER_CRLF_EN
  assign w_push      = (r_state == RD) || (r_state == GAP && r_crlf);
  assign w_push_data = (r_state == GAP) ? 8'h0A : databus;
`else
  assign w_push      = (r_state == RD);
  assign w_push_data = databus;
`endif
  assign w_pop  = (r_state == WR);
  assign w_room = (32'(w_count) + RD_SLOTS) <= DEPTH;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Outputs are loaded together with the state they belong to. Out of reset,
  // CFG_LO first spends one cycle with iocs low to issue its own access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CFG_LO;
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b1;
      r_ioaddr   <= ADDR_BUF;
      r_drive    <= 1'b0;
      r_dout     <= '0;
      r_br       <= br_cfg;
      r_cfg_done <= 1'b0;
`ifdef SPART_DRIVER_CRLF_EN
      r_crlf     <= 1'b0;
`endif
    end else begin
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= ADDR_BUF;
      r_drive  <= 1'b0;
      case (r_state)
        CFG_LO: begin
          r_iocs  <= 1'b1;
          r_iorw  <= 1'b0;
          r_drive <= 1'b1;
          if (!r_iocs) begin
            r_ioaddr <= ADDR_DBL;
            r_dout   <= DIV[r_br][7:0];
          end else begin
            r_state  <= CFG_HI;
            r_ioaddr <= ADDR_DBH;
            r_dout   <= DIV[r_br][15:8];
          end
        end
        CFG_HI: begin
          r_state    <= IDLE;
          r_cfg_done <= 1'b1;
        end
        IDLE: begin
          if (br_cfg != r_br) begin
            r_br       <= br_cfg;
            r_cfg_done <= 1'b0;
            r_state    <= CFG_LO;
            r_iocs     <= 1'b1;
            r_iorw     <= 1'b0;
            r_ioaddr   <= ADDR_DBL;
            r_drive    <= 1'b1;
            r_dout     <= DIV[br_cfg][7:0];
          end else if (rda && w_room) begin
            r_state <= RD;
            r_iocs  <= 1'b1;
          end else if (tbr && !w_empty) begin
            r_state <= WR;
            r_iocs  <= 1'b1;
            r_iorw  <= 1'b0;
            r_drive <= 1'b1;
            r_dout  <= w_head;
          end
        end
        RD: begin
          r_state <= GAP;
`ifdef SPART_DRIVER_CRLF_EN
          r_crlf  <= (databus == 8'h0D);
`endif
        end
        WR: r_state <= GAP;
        GAP: begin
          r_state <= IDLE;
`ifdef SPART_DRIVER_CRLF_EN
          r_crlf  <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign iocs       = r_iocs;
  assign iorw       = r_iorw;
  assign ioaddr     = r_ioaddr;
  assign databus    = r_drive ? r_dout : 'z;
  assign fifo_level = w_count;
  assign cfg_done   = r_cfg_done;

  logic w_unused;
  assign w_unused = w_full;

endmodule
